bus_arbiter: RTL and testbench

Round-robin arbiter and capture stage for the shared tri-state bus formed by several `Buffer` instances. It drives their one-hot `en` lines, so at most one source ever drives the bus. It inserts a dead turnaround cycle between owners and registers the resolved bus value, with source ID, for the downstream consumer. It sits directly upstream of the `Buffer` enables and directly downstream of the shared `out` net.

---
 rtl/bus_arbiter_pkg.sv | 17 +
 rtl/bus_arbiter_rr_pick.sv | 34 +++
 rtl/bus_arbiter.sv | 85 ++++++++
 tb/tb_bus_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared state encodings and default sizes for the bus arbiter
package bus_arbiter_pkg;

  // Arbiter FSM states; encodings are shared with the Buffer parents
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_TURN  = 2'b10
  } state_t;

  // Defaults shared with the Buffer parents
  localparam int DEF_N        = 4;
  localparam int DEF_IDW      = 2;
  localparam int DEF_BIT      = 4;
  localparam int DEF_MAX_HOLD = 4;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - rotating-priority search starting just after the last owner
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int IDW = DEF_IDW
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic           found,
  output logic [IDW-1:0] idx
);

  // Candidate index, one bit wider so last+i can be reduced modulo N
  logic [IDW:0] j;

  // Scan last+1, last+2, ... modulo N; the first set request wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = 1; i <= N; i++) begin
      j = {1'b0, last} + (IDW+1)'(i);
      if (j >= (IDW+1)'(N)) begin
        j = j - (IDW+1)'(N);
      end
      if (!found && req[j[IDW-1:0]]) begin
        found = 1'b1;
        idx   = j[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin owner selection, turnaround insertion and bus capture
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int IDW      = DEF_IDW,
  parameter int BIT      = DEF_BIT,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [BIT-1:0] bus,
  output logic [N-1:0]   en,
  output logic [IDW-1:0] gnt_id,
  output logic [BIT-1:0] data_out,
  output logic [IDW-1:0] src_out,
  output logic           valid_out
);

  // Counter is wide enough to reach MAX_HOLD without wrapping
  localparam int CW = $clog2(MAX_HOLD) + 1;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] last;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;

  bus_arbiter_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Arbiter FSM: grant, hold up to MAX_HOLD captures, then one dead cycle before the next owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      en        <= '0;
      gnt_id    <= '0;
      cnt       <= '0;
      last      <= IDW'(N-1);
      data_out  <= '0;
      src_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        ST_IDLE, ST_TURN: begin
          if (pick_found) begin
            state  <= ST_GRANT;
            en     <= N'(1) << pick_idx;
            gnt_id <= pick_idx;
            cnt    <= '0;
          end else begin
            state <= ST_IDLE;
            en    <= '0;
          end
        end
        ST_GRANT: begin
          data_out  <= bus;
          src_out   <= gnt_id;
          valid_out <= 1'b1;
          cnt       <= cnt + 1'b1;
          // The capture on the releasing edge still counts as a valid beat
          if (!req[gnt_id] || cnt == CW'(MAX_HOLD-1)) begin
            state <= ST_TURN;
            en    <= '0;
            last  <= gnt_id;
          end
        end
        default: begin
          state <= ST_IDLE;
          en    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and random checks of the bus arbiter
module tb_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  bus;
  logic [3:0]  en;
  logic [1:0]  gnt_id;
  logic [3:0]  data_out;
  logic [1:0]  src_out;
  logic        valid_out;

  logic [1:0]  req_w;
  logic [15:0] bus_w;
  logic [1:0]  en_w;
  logic [0:0]  gnt_w;
  logic [15:0] data_w;
  logic [0:0]  src_w;
  logic        valid_w;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.N(4), .IDW(2), .BIT(4), .MAX_HOLD(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .bus       (bus),
    .en        (en),
    .gnt_id    (gnt_id),
    .data_out  (data_out),
    .src_out   (src_out),
    .valid_out (valid_out)
  );

  bus_arbiter #(.N(2), .IDW(1), .BIT(16), .MAX_HOLD(4)) u_wide (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_w),
    .bus       (bus_w),
    .en        (en_w),
    .gnt_id    (gnt_w),
    .data_out  (data_w),
    .src_out   (src_w),
    .valid_out (valid_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source i drives 8+i when enabled (source 2 drives 4'hA)
  always_comb begin
    bus = '0;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) bus = bus | (4'h8 + 4'(i));
    end
  end

  always_comb begin
    bus_w = '0;
    if (en_w[0]) bus_w = bus_w | 16'h1234;
    if (en_w[1]) bus_w = bus_w | 16'hBEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    req_w = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    req_w = '0;
    tick();
    checks++; if (en !== 4'b0000) begin errors++; $display("FAIL reset_en: got %b expected 0000", en); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt: got %0d expected 0", gnt_id); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (data_out !== 4'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_out); end
    checks++; if (src_out !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d expected 0", src_out); end
    rst_n = 1'b1;
    req   = 4'b0010;
    tick();
    checks++; if (en !== 4'b0010) begin errors++; $display("FAIL reset_pre_grant: got %b expected 0010", en); end
    tick();
    checks++; if (valid_out !== 1'b1 || data_out !== 4'h9) begin errors++; $display("FAIL reset_pre_capture: got valid=%b data=%h expected valid=1 data=9", valid_out, data_out); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (en !== 4'b0000) begin errors++; $display("FAIL reset_async_en: got %b expected 0000", en); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_async_valid: got %b expected 0", valid_out); end
    checks++; if (data_out !== 4'h0) begin errors++; $display("FAIL reset_async_data: got %h expected 0", data_out); end
    req = 4'b0001;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (en !== 4'b0001) begin errors++; $display("FAIL reset_release_grant: got %b expected 0001", en); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    tick();
    checks++; if (en !== 4'b0100 || valid_out !== 1'b0) begin errors++; $display("FAIL single_grant: got en=%b valid=%b expected en=0100 valid=0", en, valid_out); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (en !== 4'b0100 || valid_out !== 1'b1 || data_out !== 4'hA || src_out !== 2'd2) begin errors++; $display("FAIL single_hold%0d: got en=%b valid=%b data=%h src=%0d expected en=0100 valid=1 data=a src=2", c, en, valid_out, data_out, src_out); end
    end
    tick();
    checks++; if (en !== 4'b0000 || valid_out !== 1'b1 || data_out !== 4'hA) begin errors++; $display("FAIL single_turn: got en=%b valid=%b data=%h expected en=0000 valid=1 data=a", en, valid_out, data_out); end
    tick();
    checks++; if (en !== 4'b0100 || valid_out !== 1'b0) begin errors++; $display("FAIL single_regrant: got en=%b valid=%b expected en=0100 valid=0", en, valid_out); end
  endtask

  task automatic test_round_robin();
    int o;
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      o = t % 4;
      for (int c = 0; c < 4; c++) begin
        tick();
        checks++; if (en !== (4'b0001 << o) || gnt_id !== 2'(o)) begin errors++; $display("FAIL rr_tenure%0d_cycle%0d: got en=%b gnt=%0d expected en=%b gnt=%0d", t, c, en, gnt_id, 4'b0001 << o, o); end
      end
      if (t < 4) begin
        tick();
        checks++; if (en !== 4'b0000 || valid_out !== 1'b1 || src_out !== 2'(o)) begin errors++; $display("FAIL rr_turn%0d: got en=%b valid=%b src=%0d expected en=0000 valid=1 src=%0d", t, en, valid_out, src_out, o); end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b1010;
    tick();
    checks++; if (en !== 4'b0010) begin errors++; $display("FAIL early_grant: got %b expected 0010", en); end
    tick();
    checks++; if (valid_out !== 1'b1 || src_out !== 2'd1 || data_out !== 4'h9 || en !== 4'b0010) begin errors++; $display("FAIL early_cap1: got valid=%b src=%0d data=%h en=%b expected valid=1 src=1 data=9 en=0010", valid_out, src_out, data_out, en); end
    req = 4'b1000;
    tick();
    checks++; if (valid_out !== 1'b1 || src_out !== 2'd1 || en !== 4'b0000) begin errors++; $display("FAIL early_cap2: got valid=%b src=%0d en=%b expected valid=1 src=1 en=0000", valid_out, src_out, en); end
    tick();
    checks++; if (en !== 4'b1000 || valid_out !== 1'b0) begin errors++; $display("FAIL early_next: got en=%b valid=%b expected en=1000 valid=0", en, valid_out); end
    tick();
    checks++; if (valid_out !== 1'b1 || src_out !== 2'd3 || data_out !== 4'hB) begin errors++; $display("FAIL early_cap3: got valid=%b src=%0d data=%h expected valid=1 src=3 data=b", valid_out, src_out, data_out); end
  endtask

  task automatic test_contention();
    logic [3:0] prev_en;
    int pulses;
    do_reset();
    prev_en = en;
    pulses  = 0;
    for (int n = 0; n < 2000; n++) begin
      req = 4'($urandom_range(0, 15));
      tick();
      checks++; if ($countones(en) > 1) begin errors++; $display("FAIL cont_onehot cycle %0d: got en=%b expected at most one bit", n, en); end
      checks++; if (en != 0 && prev_en != 0 && en != prev_en) begin errors++; $display("FAIL cont_turnaround cycle %0d: got en %b after %b expected a zero cycle between", n, en, prev_en); end
      checks++; if (en != 0 && en !== (4'b0001 << gnt_id)) begin errors++; $display("FAIL cont_gnt cycle %0d: got gnt=%0d en=%b expected matching index", n, gnt_id, en); end
      checks++; if (en != 0 && $isunknown(bus)) begin errors++; $display("FAIL cont_bus_x cycle %0d: got bus=%h expected known", n, bus); end
      if (valid_out) begin
        pulses++;
        checks++; if (data_out !== 4'h8 + 4'(src_out)) begin errors++; $display("FAIL cont_data cycle %0d: got data=%h expected %h", n, data_out, 4'h8 + 4'(src_out)); end
      end
      prev_en = en;
    end
    checks++; if (pulses == 0) begin errors++; $display("FAIL cont_activity: got %0d captures expected some", pulses); end
    req = '0;
  endtask

  task automatic test_width();
    do_reset();
    req_w = 2'b11;
    tick();
    checks++; if (en_w !== 2'b01) begin errors++; $display("FAIL width_grant0: got %b expected 01", en_w); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (valid_w !== 1'b1 || data_w !== 16'h1234 || src_w !== 1'b0) begin errors++; $display("FAIL width_cap0_%0d: got valid=%b data=%h src=%0d expected valid=1 data=1234 src=0", c, valid_w, data_w, src_w); end
    end
    tick();
    checks++; if (en_w !== 2'b10 || valid_w !== 1'b0) begin errors++; $display("FAIL width_grant1: got en=%b valid=%b expected en=10 valid=0", en_w, valid_w); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (valid_w !== 1'b1 || data_w !== 16'hBEEF || src_w !== 1'b1) begin errors++; $display("FAIL width_cap1_%0d: got valid=%b data=%h src=%0d expected valid=1 data=beef src=1", c, valid_w, data_w, src_w); end
    end
    tick();
    checks++; if (en_w !== 2'b01) begin errors++; $display("FAIL width_regrant0: got %b expected 01", en_w); end
    req_w = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    req_w = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_contention();
    test_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
